bus_cycle_controller: RTL and testbench
=======================================

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk4 (rising edge) and reset.
REQ-002 clk4  input  1  system clock; the same clk4 that advances the uPC.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 nmem  input  1  active-low memory-space request from the microcode control vector.
REQ-005 nio  input  1  active-low I/O-space request from the microcode control vector.
REQ-006 nr  input  1  direction: 0 = read, 1 = write; sampled only when a cycle starts.
REQ-007 nhalt  input  1  active-low halt; blocks new cycles only.
REQ-008 nwaitext  input  1  active-low device wait request.
REQ-009 nws  output  1  active-low wait state to the sequencer's uPC count-enable; low stalls the uPC.
REQ-010 nmemreq  output  1  registered, active-low memory-space bus strobe.
REQ-011 nioreq  output  1  registered, active-low I/O-space bus strobe.
REQ-012 nrd  output  1  registered, active-low read strobe.
REQ-013 nwr  output  1  registered, active-low write strobe.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 nbuserr  output  1  registered, active-low one-cycle bus error pulse.

Function
REQ-016 State machine SHALL have states IDLE, ADDR, STROBE, END and ERR.
REQ-017 Request is defined as (nmem low XOR nio low) AND nhalt high.
- IDLE -> ADDR on request.
- IDLE -> ERR when nmem and nio are both low and nhalt is high.
- Otherwise IDLE is held.
REQ-018 On IDLE -> ADDR the block SHALL latch space (mem or io) and direction (nr); input changes after that edge SHALL be ignored until IDLE.
REQ-019 ADDR: asserts only the latched space strobe for 1 cycle; next state is STROBE.
REQ-020 STROBE: space strobe is held and nrd (read) or nwr (write) is asserted; the state is held while nwaitext is sampled low, and moves to END when nwaitext is sampled high.
REQ-021 END: all strobes deasserted; next state is IDLE.
REQ-022 ERR: nbuserr low for exactly 1 cycle, no strobes; next state is IDLE.
REQ-023 nws SHALL be combinational:
- low in IDLE when a request or an illegal both-low request is present;
- low in ADDR and STROBE;
- high in END, ERR, and in IDLE without a request.
REQ-024 No-wait cycle latency: nws low for exactly 3 clocks; the uPC advances on the 4th rising edge after the request appears.
REQ-025 nrd and nwr SHALL never be low simultaneously; nmemreq and nioreq SHALL never be low simultaneously.
REQ-026 A request present in the cycle after END SHALL start a new cycle (back-to-back allowed); there is no dead cycle beyond END.
REQ-027 nhalt going low during ADDR or STROBE SHALL NOT abort the cycle; the cycle completes to END.

Reset
REQ-028 On reset sampled high: state = IDLE, latched space and direction cleared, 4-bit timeout counter = 0.
REQ-029 Reset output values: nmemreq = nioreq = nrd = nwr = nbuserr = 1, busy = 0.
REQ-030 Reset mid-cycle SHALL deassert all strobes at that same edge, with no END state and no nbuserr pulse.
REQ-031 Reset SHALL have priority over every other transition.

Configuration
REQ-032 Macro BUS_TIMEOUT_EN SHALL control the STROBE timeout.
- Defined: a 4-bit counter clears on entry to STROBE and increments each STROBE cycle with nwaitext low. When the counter is 15 and nwaitext is still low, next state is END and nbuserr is low for exactly the END cycle.
- Undefined: no counter; nbuserr tied high except in ERR; STROBE waits indefinitely.

Verification
REQ-033 Read, no wait: nmem=0, nr=0, nwaitext=1 at cycle 0 -> nws low cycles 0-2, nmemreq low cycles 2-3, nrd low cycle 3 only, busy high cycles 1-4.
REQ-034 I/O write, 2 wait cycles: nio=0, nr=1, nwaitext low for 2 STROBE samples -> nwr low 3 cycles, nws low 5 cycles, nmemreq stays high.
REQ-035 Illegal request: nmem=nio=0 -> nbuserr low exactly 1 cycle, no strobe asserted, nws low only in the detect cycle.
REQ-036 Reset mid-STROBE: reset=1 for 1 cycle during STROBE -> all strobes high next cycle, busy=0, nbuserr stays high.
REQ-037 Timeout with BUS_TIMEOUT_EN defined: nwaitext held low -> END after 16 STROBE cycles with nbuserr low 1 cycle. With the macro undefined: still in STROBE after 100 cycles.
REQ-038 Halt and direction change: nhalt=0 with nmem=0 -> state stays IDLE and nws high. nr toggled during STROBE -> strobe type unchanged.

Source files
------------

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: microcode bus cycle sequencer (IDLE/ADDR/STROBE/END/ERR) with uPC wait-state output.
// Optional STROBE timeout with bus error is built when BUS_TIMEOUT_EN is defined.
module bus_cycle_controller (
    input  logic clk4,
    input  logic reset,
    input  logic nmem,
    input  logic nio,
    input  logic nr,
    input  logic nhalt,
    input  logic nwaitext,
    output logic nws,
    output logic nmemreq,
    output logic nioreq,
    output logic nrd,
    output logic nwr,
    output logic busy,
    output logic nbuserr
);
    typedef enum logic [2:0] {IDLE, ADDR, STROBE, END, ERR} state_t;
    state_t state, next;
    logic req, illegal, timeout, busy_q, sp_io, dir_wr, active;
    logic mem_d, io_d, rd_d, wr_d, err_d;
    assign req     = ((!nmem) ^ (!nio)) && nhalt;
    assign illegal = !nmem && !nio && nhalt;
`ifdef BUS_TIMEOUT_EN
    logic [3:0] cnt;
    assign timeout = state == STROBE && !nwaitext && cnt == 4'd15;
    always_ff @(posedge clk4) begin
        if (reset || state == ADDR)
            cnt <= 4'd0;
        else if (state == STROBE && !nwaitext)
            cnt <= cnt + 4'd1;
    end
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk4) begin
        if (reset) begin
            state   <= IDLE;
            sp_io   <= 1'b0;
            dir_wr  <= 1'b0;
            busy_q  <= 1'b0;
            nmemreq <= 1'b1;
            nioreq  <= 1'b1;
            nrd     <= 1'b1;
            nwr     <= 1'b1;
            nbuserr <= 1'b1;
        end else begin
            state   <= next;
            busy_q  <= state != IDLE;
            if (state == IDLE && req) begin
                sp_io  <= !nio;
                dir_wr <= nr;
            end
            nmemreq <= mem_d;
            nioreq  <= io_d;
            nrd     <= rd_d;
            nwr     <= wr_d;
            nbuserr <= err_d;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req ? ADDR : illegal ? ERR : IDLE;
            ADDR:    next = STROBE;
            STROBE:  next = (nwaitext || timeout) ? END : STROBE;
            default: next = IDLE;
        endcase
    end
    // Strobes lag the state by one clock; busy also covers that bus-release cycle.
    always_comb begin
        active = state == ADDR || state == STROBE;
        nws    = !((state == IDLE && (req || illegal)) || active);
        mem_d  = !(active && !sp_io);
        io_d   = !(active && sp_io);
        rd_d   = !(state == STROBE && !dir_wr);
        wr_d   = !(state == STROBE && dir_wr);
        err_d  = !(next == ERR || timeout);
        busy   = state != IDLE || busy_q;
    end
endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb_bus_cycle_controller: random transaction stream checked against a per-transaction timing schedule.
module tb_bus_cycle_controller;
    logic clk4 = 1'b0;
    logic reset, nmem, nio, nr, nhalt, nwaitext;
    logic nws, nmemreq, nioreq, nrd, nwr, busy, nbuserr;
    int checks = 0;
    int errors = 0;
    bit tail = 1'b0;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    bus_cycle_controller dut (
        .clk4(clk4), .reset(reset), .nmem(nmem), .nio(nio), .nr(nr), .nhalt(nhalt),
        .nwaitext(nwaitext), .nws(nws), .nmemreq(nmemreq), .nioreq(nioreq),
        .nrd(nrd), .nwr(nwr), .busy(busy), .nbuserr(nbuserr)
    );

    always #5 clk4 = ~clk4;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {nws,busy,mem,io,rd,wr,err}=%b expected %b", tag, got, exp);
        end
    endtask

    // kind: 0 mem, 1 io, 2 illegal, 3 halted request, 4 no request
    // w: STROBE samples with nwaitext low; rst_at: cycle offset carrying reset (0 = none)
    task automatic txn(input int kind, input bit wr, input int w, input int rst_at, input string name);
        int s, len;
        bit tmo, aborted;
        logic e_nws, e_busy, e_mem, e_io, e_rd, e_wr, e_err;
        tmo = TO && w >= 16;
        s = tmo ? 16 : w + 1;
        len = kind <= 1 ? 3 + s : kind == 2 ? 2 : 1;
        aborted = rst_at > 0 && rst_at < len;
        if (aborted) len = rst_at + 1;
        for (int c = 0; c < len; c++) begin
            @(posedge clk4);
            #1;
            reset = rst_at > 0 && c == rst_at;
            if (c == 0) begin
                case (kind)
                    0:       begin nmem = 1'b0; nio = 1'b1; nhalt = 1'b1; end
                    1:       begin nmem = 1'b1; nio = 1'b0; nhalt = 1'b1; end
                    2:       begin nmem = 1'b0; nio = 1'b0; nhalt = 1'b1; end
                    3:       begin nmem = 1'b0; nio = 1'($urandom); nhalt = 1'b0; end
                    default: begin nmem = 1'b1; nio = 1'b1; nhalt = 1'($urandom); end
                endcase
                nr = wr;
            end else begin
                nmem  = 1'($urandom);
                nio   = 1'($urandom);
                nr    = 1'($urandom);
                nhalt = 1'($urandom);
            end
            nwaitext = (kind <= 1 && c >= 2) ? (c - 2 >= w) : 1'($urandom);
            @(negedge clk4);
            e_busy = c == 0 ? tail : 1'b1;
            e_nws = 1'b1; e_mem = 1'b1; e_io = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_err = 1'b1;
            if (kind <= 1) begin
                e_nws = !(c <= 1 + s);
                e_mem = !(kind == 0 && c >= 2 && c <= 2 + s);
                e_io  = !(kind == 1 && c >= 2 && c <= 2 + s);
                e_rd  = !(!wr && c >= 3 && c <= 2 + s);
                e_wr  = !(wr && c >= 3 && c <= 2 + s);
                e_err = !(tmo && c == 2 + s);
            end else if (kind == 2) begin
                e_nws = c != 0;
                e_err = c != 1;
            end
            check($sformatf("%s c%0d", name, c), {nws, busy, nmemreq, nioreq, nrd, nwr, nbuserr},
                  {e_nws, e_busy, e_mem, e_io, e_rd, e_wr, e_err});
        end
        tail = !aborted && kind <= 2;
    endtask

    initial begin
        int k, w, r;
        reset = 1'b1; nmem = 1'b1; nio = 1'b1; nr = 1'b0; nhalt = 1'b1; nwaitext = 1'b1;
        repeat (3) @(posedge clk4);
        #1 reset = 1'b0;
        @(negedge clk4);
        check("reset", {nws, busy, nmemreq, nioreq, nrd, nwr, nbuserr}, 7'b1011111);
        txn(0, 1'b0, 0, 0, "rd_nowait");
        txn(1, 1'b1, 2, 0, "io_wr_wait2");
        txn(2, 1'b0, 0, 0, "illegal");
        txn(3, 1'b0, 0, 0, "halted");
        txn(0, 1'b0, 3, 4, "rst_strobe");
        txn(4, 1'b0, 0, 0, "after_rst");
        txn(0, 1'b0, 0, 0, "b2b_a");
        txn(1, 1'b0, 1, 0, "b2b_b");
        txn(1, 1'b1, TO ? 20 : 100, 0, "timeout");
        txn(2, 1'b0, 0, 1, "rst_err");
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            k = k <= 2 ? 0 : k <= 5 ? 1 : k == 6 ? 2 : k == 7 ? 3 : 4;
            w = $urandom_range(0, 15) == 0 ? 17 : $urandom_range(0, 4);
            r = $urandom_range(0, 9) == 0 ? $urandom_range(1, 6) : 0;
            txn(k, 1'($urandom), w, r, $sformatf("rnd%0d", i));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
